// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between apb_bridge and apb_slave_regfile
interface apb_slave_regfile_if #(
    parameter int WIDTH = 16
);
    logic             pselect;
    logic             penable;
    logic             pwrite;
    logic [WIDTH-1:0] paddr;
    logic [WIDTH-1:0] pwdata;
    logic             pready;
    logic [WIDTH-1:0] prdata;
    logic             pslverr;

    modport master (
        output pselect,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  pready,
        input  prdata,
        input  pslverr
    );

    modport slave (
        input  pselect,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output pready,
        output prdata,
        output pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB register file with wait states; APB_SLV_PSLVERR_EN enables pslverr on out-of-range access
module apb_slave_regfile #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 0,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic             pclk,
    input  logic             preset_n,
    apb_slave_regfile_if.slave bus,
    output logic             wr_strobe,
    output logic [IDX_W-1:0] wr_idx
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_chk
        $error("WAIT_STATES must be in 0..15");
    end

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wd_q;
    logic             wr_q;
    logic [3:0]       wait_cnt;
    logic [WIDTH-1:0] regs [DEPTH];

    logic             setup_seen;
    logic             complete;
    logic             commit;
    logic             in_range;
    logic [IDX_W-1:0] idx_q;

    assign setup_seen = bus.pselect && !bus.penable;
    assign idx_q      = addr_q[IDX_W-1:0];
    // Range is judged on the latched address so it is stable for the whole ACCESS phase.
    assign in_range   = (addr_q[WIDTH-1:IDX_W] == '0);
    assign complete   = (state == S_ACCESS) && bus.pselect && bus.penable && bus.pready;
    assign commit     = complete && wr_q && in_range;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (setup_seen) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus.pselect || !bus.penable) begin
                    state_nxt = S_IDLE;
                end else if (bus.pready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // pready decodes registered state only, so the bridge sees no combinational loop.
    always_comb begin
        bus.pready  = (state == S_ACCESS) && (wait_cnt == 4'd0);
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        if (bus.pready && !wr_q && in_range) begin
            bus.prdata = regs[idx_q];
        end
`ifdef APB_SLV_PSLVERR_EN
        bus.pslverr = bus.pready && !in_range;
`else
        bus.pslverr = 1'b0;
`endif
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            addr_q   <= '0;
            wd_q     <= '0;
            wr_q     <= 1'b0;
            wait_cnt <= 4'd0;
        end else if (state == S_IDLE) begin
            if (setup_seen) begin
                addr_q   <= bus.paddr;
                wd_q     <= bus.pwdata;
                wr_q     <= bus.pwrite;
                wait_cnt <= WAIT_INIT;
            end
        end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[idx_q] <= wd_q;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_strobe <= 1'b0;
            wr_idx    <= '0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                wr_idx <= idx_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - randomized self-checking bench for apb_slave_regfile at WAIT_STATES 0, 2 and 3
module tb_apb_slave_regfile;

    localparam int N = 3;
    localparam int D = 8;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel [N];
    logic        pen  [N];
    logic        pwr  [N];
    logic [15:0] padr [N];
    logic [15:0] pwd  [N];
    logic        rdy  [N];
    logic        err  [N];
    logic [15:0] rdat [N];
    logic        stb  [N];
    logic [2:0]  idx  [N];

    logic [15:0] model [N][D];
    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile_if #(.WIDTH(16)) bus0 ();
    apb_slave_regfile_if #(.WIDTH(16)) bus1 ();
    apb_slave_regfile_if #(.WIDTH(16)) bus2 ();

    assign bus0.pselect = psel[0];
    assign bus0.penable = pen[0];
    assign bus0.pwrite  = pwr[0];
    assign bus0.paddr   = padr[0];
    assign bus0.pwdata  = pwd[0];
    assign rdy[0]  = bus0.pready;
    assign rdat[0] = bus0.prdata;
    assign err[0]  = bus0.pslverr;

    assign bus1.pselect = psel[1];
    assign bus1.penable = pen[1];
    assign bus1.pwrite  = pwr[1];
    assign bus1.paddr   = padr[1];
    assign bus1.pwdata  = pwd[1];
    assign rdy[1]  = bus1.pready;
    assign rdat[1] = bus1.prdata;
    assign err[1]  = bus1.pslverr;

    assign bus2.pselect = psel[2];
    assign bus2.penable = pen[2];
    assign bus2.pwrite  = pwr[2];
    assign bus2.paddr   = padr[2];
    assign bus2.pwdata  = pwd[2];
    assign rdy[2]  = bus2.pready;
    assign rdat[2] = bus2.prdata;
    assign err[2]  = bus2.pslverr;

    apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .preset_n(preset_n), .bus(bus0), .wr_strobe(stb[0]), .wr_idx(idx[0])
    );
    apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .preset_n(preset_n), .bus(bus1), .wr_strobe(stb[1]), .wr_idx(idx[1])
    );
    apb_slave_regfile #(.WIDTH(16), .DEPTH(8), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .preset_n(preset_n), .bus(bus2), .wr_strobe(stb[2]), .wr_idx(idx[2])
    );

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit err_expected(input bit in_rng);
`ifdef APB_SLV_PSLVERR_EN
        return !in_rng;
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_model();
        for (int d = 0; d < N; d++)
            for (int i = 0; i < D; i++)
                model[d][i] = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Starts at posedge+1 and returns at posedge+1, so calls chain back-to-back.
    task automatic xfer(input int d, input bit w, input logic [15:0] a, input logic [15:0] v);
        int          c;
        bit          done;
        bit          in_rng;
        bit          exp_stb;
        logic [15:0] exp_rd;
        in_rng  = (a[15:3] == 13'd0);
        psel[d] = 1'b1;
        pen[d]  = 1'b0;
        pwr[d]  = w;
        padr[d] = a;
        pwd[d]  = v;
        @(posedge pclk);
        #1 pen[d] = 1'b1;
        c    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge pclk);
            if (rdy[d] === 1'b1) begin
                done = 1'b1;
                checks++;
                if (c != ws_of(d)) begin
                    errors++;
                    $display("FAIL latency dut%0d addr=%h: got %0d wait cycles, expected %0d", d, a, c, ws_of(d));
                end
                exp_rd = (!w && in_rng) ? model[d][a[2:0]] : 16'h0000;
                checks++;
                if (rdat[d] !== exp_rd) begin
                    errors++;
                    $display("FAIL prdata dut%0d addr=%h: got %h, expected %h", d, a, rdat[d], exp_rd);
                end
                checks++;
                if (err[d] !== err_expected(in_rng)) begin
                    errors++;
                    $display("FAIL pslverr dut%0d addr=%h: got %b, expected %b", d, a, err[d], err_expected(in_rng));
                end
            end else begin
                c++;
                if (c > 20) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout dut%0d addr=%h: pready never rose", d, a);
                    done = 1'b1;
                end
            end
        end
        @(posedge pclk);
        #1;
        psel[d] = 1'b0;
        pen[d]  = 1'b0;
        exp_stb = w && in_rng;
        if (exp_stb) model[d][a[2:0]] = v;
        checks++;
        if (stb[d] !== exp_stb) begin
            errors++;
            $display("FAIL wr_strobe dut%0d addr=%h: got %b, expected %b", d, a, stb[d], exp_stb);
        end
        if (exp_stb) begin
            checks++;
            if (idx[d] !== a[2:0]) begin
                errors++;
                $display("FAIL wr_idx dut%0d: got %0d, expected %0d", d, idx[d], a[2:0]);
            end
        end
        checks++;
        if (rdy[d] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after dut%0d: pready got %b, expected 0", d, rdy[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0; padr[d] = '0; pwd[d] = '0;
        end
        clear_model();
        preset_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int d = 0; d < N; d++) begin
            checks++;
            if (rdy[d] !== 1'b0 || rdat[d] !== 16'h0 || stb[d] !== 1'b0 || idx[d] !== 3'd0 || err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: pready=%b prdata=%h strobe=%b idx=%0d pslverr=%b, expected all 0",
                         d, rdy[d], rdat[d], stb[d], idx[d], err[d]);
            end
        end
        preset_n = 1'b1;
        idle(1);
        for (int d = 0; d < N; d++)
            for (int i = 0; i < D; i++)
                xfer(d, 1'b0, 16'(i), 16'h0);
    endtask

    task automatic test_zero_wait();
        xfer(0, 1'b1, 16'h0003, 16'hA5A5);
        xfer(0, 1'b0, 16'h0003, 16'h0);
        checks++;
        if (model[0][3] !== 16'hA5A5) begin
            errors++;
            $display("FAIL zero_wait_model: got %h, expected a5a5", model[0][3]);
        end
        idle(1);
    endtask

    task automatic test_wait_states();
        xfer(1, 1'b1, 16'h0005, 16'h1234);
        xfer(1, 1'b0, 16'h0005, 16'h0);
        xfer(2, 1'b1, 16'h0004, 16'h4321);
        xfer(2, 1'b0, 16'h0004, 16'h0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < N; d++) begin
            xfer(d, 1'b1, 16'h0000, 16'h0001);
            xfer(d, 1'b1, 16'h0001, 16'h0002);
            xfer(d, 1'b1, 16'h0002, 16'h0003);
            xfer(d, 1'b0, 16'h0000, 16'h0);
            xfer(d, 1'b0, 16'h0001, 16'h0);
            xfer(d, 1'b0, 16'h0002, 16'h0);
            idle(1);
        end
    endtask

    task automatic test_out_of_range();
        for (int d = 0; d < N; d++) begin
            xfer(d, 1'b1, 16'h0010, 16'hFFFF);
            xfer(d, 1'b0, 16'h0010, 16'h0);
            xfer(d, 1'b0, 16'h0000, 16'h0);
            xfer(d, 1'b1, 16'h8003, 16'hDEAD);
            xfer(d, 1'b0, 16'h0003, 16'h0);
            idle(1);
        end
    endtask

    task automatic test_abort();
        xfer(2, 1'b1, 16'h0006, 16'h5555);
        psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1; padr[2] = 16'h0006; pwd[2] = 16'hAAAA;
        @(posedge pclk);
        #1 pen[2] = 1'b1;
        @(posedge pclk);
        #1;
        psel[2] = 1'b0;
        pen[2]  = 1'b0;
        @(posedge pclk);
        #1;
        checks++;
        if (rdy[2] !== 1'b0 || stb[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: pready=%b strobe=%b, expected 0 0", rdy[2], stb[2]);
        end
        repeat (3) begin
            @(posedge pclk);
            #1;
            checks++;
            if (rdy[2] !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_ready: pready got %b, expected 0", rdy[2]);
            end
        end
        xfer(2, 1'b0, 16'h0006, 16'h0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        psel[2] = 1'b1; pen[2] = 1'b0; pwr[2] = 1'b1; padr[2] = 16'h0007; pwd[2] = 16'hBEEF;
        @(posedge pclk);
        #1 pen[2] = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        checks++;
        if (rdy[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready_before: pready got %b, expected 1", rdy[2]);
        end
        preset_n = 1'b0;
        #1;
        checks++;
        if (rdy[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: pready got %b, expected 0", rdy[2]);
        end
        clear_model();
        psel[2] = 1'b0;
        pen[2]  = 1'b0;
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
        checks++;
        if (stb[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_strobe: got %b, expected 0", stb[2]);
        end
        idle(1);
        xfer(2, 1'b0, 16'h0007, 16'h0);
        xfer(0, 1'b0, 16'h0003, 16'h0);
        idle(1);
    endtask

    task automatic test_random();
        int          d;
        bit          w;
        logic [15:0] a;
        logic [15:0] v;
        for (int k = 0; k < 120; k++) begin
            d = int'($urandom_range(0, N - 1));
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) a = 16'($urandom) | 16'h0008;
            else                           a = 16'($urandom_range(0, D - 1));
            v = 16'($urandom);
            xfer(d, w, a, v);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        for (int dd = 0; dd < N; dd++)
            for (int i = 0; i < D; i++)
                xfer(dd, 1'b0, 16'(i), 16'h0);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_back_to_back();
        test_out_of_range();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (peripheral) that sits directly downstream of apb_bridge and consumes its pselect/penable/pwrite/paddr/pwdata.
- Returns pready/prdata to the bridge.
- Implements DEPTH read/write registers of WIDTH bits, with a programmable number of wait states per access.
- Provides a write strobe so downstream logic can react to register updates.

Parameters:
- WIDTH, 16, data and address bus width; must match apb_bridge.
- DEPTH, 8, number of registers; power of 2, at least 2; IDX_W = clog2(DEPTH).
- WAIT_STATES, 0, ACCESS-phase cycles with pready low before completion; 0 to 15.

Ports:
- pclk  in  1  peripheral clock, rising edge.
- preset_n  in  1  asynchronous, active-low reset.
- pselect  in  1  slave select from bridge.
- penable  in  1  access phase indicator from bridge.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  WIDTH  word address.
- pwdata  in  WIDTH  write data.
- pready  out  1  transfer complete.
- prdata  out  WIDTH  read data, valid only while pready=1 on a read.
- pslverr  out  1  error response, valid only while pready=1.
- wr_strobe  out  1  one-cycle pulse after a committed write.
- wr_idx  out  IDX_W  index of the last committed write.

Behaviour:
- Reset (asynchronous, active-low): all registers 0; state IDLE; wait counter 0; pready 0; prdata 0; pslverr 0; wr_strobe 0; wr_idx 0. Reset asserted mid-transfer aborts the transfer immediately; no write is committed.
- State machine has two states, IDLE and ACCESS.
- IDLE:
  - On an edge sampling pselect=1 and penable=0 (SETUP phase):
    - latch paddr, pwrite, pwdata into addr_q, wr_q, wd_q;
    - load wait_cnt = WAIT_STATES;
    - go to ACCESS.
  - pselect=1 with penable=1 seen in IDLE (no preceding setup): ignored, stay IDLE.
- ACCESS:
  - pready = (state==ACCESS && wait_cnt==0). pready is a decode of registered state only; there is no combinational path from bus inputs to pready.
  - If wait_cnt>0, decrement wait_cnt each edge.
  - Completion: an edge sampling pselect=1, penable=1, pready=1. On completion:
    - if wr_q=1 and the address is in range, regs[addr_q[IDX_W-1:0]] <= wd_q;
    - go to IDLE.
  - Abort: pselect=0 sampled while in ACCESS returns to IDLE with no write. pselect=1 with penable=0 in ACCESS is also treated as an abort.
- Latency:
  - WAIT_STATES=0 gives the standard 2-cycle transfer (SETUP, ACCESS).
  - WAIT_STATES=N gives N+2 cycles.
  - Back-to-back transfers: a new SETUP is accepted on the edge after completion (state is back in IDLE).
- Address range: in range iff paddr[WIDTH-1:IDX_W]==0. Range is decided on the latched addr_q.
- Read data:
  - prdata = regs[addr_q[IDX_W-1:0]] when pready=1, wr_q=0 and the address is in range.
  - Otherwise prdata = 0.
  - Reads return the register value as of the completion cycle.
- Write strobe: wr_strobe is registered, high for exactly one cycle after each committed write; wr_idx updates on the same edge and holds its value otherwise.
- pslverr: see Optional Feature.

Optional Feature:
- Macro: APB_SLV_PSLVERR_EN.
- Defined:
  - pslverr = pready && address out of range, for both reads and writes.
  - Out-of-range writes are discarded and prdata = 0.
- Undefined:
  - pslverr is tied to 0.
  - Out-of-range writes are silently discarded; out-of-range reads return 0.
  - All other timing is identical.

Test Plan:
- Reset check: hold preset_n=0 for 3 cycles, then release -> pready=0, prdata=0, wr_strobe=0, and reads of indices 0..7 all return 0x0000.
- Zero-wait write/read, WAIT_STATES=0: write 0xA5A5 to addr 3, then read addr 3 -> pready=1 in the first ACCESS cycle of each transfer; wr_strobe pulses once with wr_idx=3; prdata=0xA5A5 at read completion.
- Wait states, WAIT_STATES=2: write 0x1234 to addr 5 -> pready low for 2 ACCESS cycles, high on the 3rd; register written only at that edge; a read of addr 5 returns 0x1234 after 4 cycles total.
- Back-to-back: writes to addrs 0,1,2 with values 0x0001,0x0002,0x0003, SETUP immediately after each completion -> all three accepted, three wr_strobe pulses, read-back matches.
- Out-of-range, macro defined: write 0xFFFF to addr 0x0010 -> pslverr=1 with pready; no register changes; no wr_strobe. Same stimulus with macro undefined -> pslverr=0, no change.
- Abort and reset: drop pselect mid-ACCESS with WAIT_STATES=3 -> return to IDLE, target register unchanged. Assert preset_n=0 mid-ACCESS -> pready falls immediately, write not committed.
